seq_detector_param: RTL

- Parametrised serial bit-pattern detector; successor to the fixed-pattern sequence-detector FSM.
- Pattern width is a parameter; the pattern is runtime-loadable.
- Supports overlapping and non-overlapping match modes, a bit-valid qualifier and a saturating match counter.
- Sits on a serial input stream and flags each occurrence of the programmed pattern to downstream control logic.

---
 rtl/seq_detector_param_if.sv | 44 ++++
 rtl/seq_detector_param.sv | 89 ++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if
//   Bundles the serial-stream, pattern-control and match-report signals of
//   seq_detector_param. clk and rst are not part of the bundle.
//
//   Signals:
//     en          bit-valid qualifier for i
//     i           serial data bit
//     pattern     new pattern value, captured when pattern_ld=1
//     pattern_ld  load pattern and flush match history
//     overlap     1 = overlapping matches, 0 = non-overlapping
//     clr_cnt     synchronous clear of match_cnt
//     out         registered one-cycle match pulse
//     match_cnt   saturating match count
//     cnt_sat     high while match_cnt is all ones
//
//   Handshake: en is a pure valid qualifier with no ready. The detector
//   always accepts, so every cycle with en=1 and pattern_ld=0 consumes i
//   exactly once; cycles with en=0 transfer nothing.
//
//   Modports: master drives the stream and controls, slave is the detector.
interface seq_detector_param_if #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8
);
    logic                 en;
    logic                 i;
    logic [PATTERN_W-1:0] pattern;
    logic                 pattern_ld;
    logic                 overlap;
    logic                 clr_cnt;
    logic                 out;
    logic [CNT_W-1:0]     match_cnt;
    logic                 cnt_sat;

    modport master (
        output en, i, pattern, pattern_ld, overlap, clr_cnt,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
        input  en, i, pattern, pattern_ld, overlap, clr_cnt,
        output out, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial bit-pattern detector with a runtime-loadable pattern of PATTERN_W
//   bits. The first accepted bit of a sequence lines up with the pattern MSB.
//   Reports each match as a registered one-cycle pulse on out and counts
//   matches in a saturating counter.
//
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-high reset
//     bus  seq_detector_param_if.slave (stream in, match report out)
//
//   State:
//     hist     shift register of accepted bits, newest in the LSB
//     fill     number of valid bits in hist, 0..PATTERN_W
//     pat_reg  active pattern
module seq_detector_param #(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(4'b1011),
    parameter int                   CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_detector_param_if.slave   bus
);
    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [PATTERN_W-1:0] hist;
    logic [PATTERN_W-1:0] pat_reg;
    logic [FILL_W-1:0]    fill;
    logic                 out_r;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_sat_r;

    logic [PATTERN_W-1:0] hist_n;
    logic [FILL_W-1:0]    fill_n;
    logic                 accept;
    logic                 match;
    logic [CNT_W-1:0]     cnt_n;

    always_comb begin
        hist_n = {hist[PATTERN_W-2:0], bus.i};
        fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_ONE;
        // A bit arriving together with pattern_ld is discarded.
        accept = bus.en && !bus.pattern_ld;
        match  = accept && (fill_n == FILL_FULL) && (hist_n == pat_reg);
        // clr_cnt wins over a simultaneous match; the counter parks at all ones.
        if (bus.clr_cnt) begin
            cnt_n = '0;
        end else if (match && !cnt_sat_r) begin
            cnt_n = cnt + CNT_ONE;
        end else begin
            cnt_n = cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            pat_reg   <= PATTERN_RST;
            out_r     <= 1'b0;
            cnt       <= '0;
            cnt_sat_r <= 1'b0;
        end else begin
            if (bus.pattern_ld) begin
                pat_reg <= bus.pattern;
                hist    <= '0;
                fill    <= '0;
                out_r   <= 1'b0;
            end else if (bus.en) begin
                hist  <= hist_n;
                // Non-overlapping mode restarts the bit count after a match.
                fill  <= (match && !bus.overlap) ? '0 : fill_n;
                out_r <= match;
            end else begin
                out_r <= 1'b0;
            end
            cnt       <= cnt_n;
            cnt_sat_r <= (cnt_n == {CNT_W{1'b1}});
        end
    end

    assign bus.out       = out_r;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = cnt_sat_r;
endmodule
